// File: rtl/alu_seq_pkg.sv
// Shared opcode, state and flag definitions for the handshaked sequential ALU.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_NAND = 4'd5;
  localparam logic [3:0] OP_NOR  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  typedef struct packed {
    logic carry;
    logic zero;
    logic ovf;
  } alu_flags_t;

  // Number of operand_b bits that form the shift amount.
  function automatic int unsigned shamt_width(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, WIDTH cycles total.
module alu_seq_mul #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    r_cnt;
  logic             r_run;
  logic             r_done;
  logic [PW-1:0]    w_pp;

  assign w_pp = r_mplier[0] ? r_mcand : '0;

  // Bit 0 is folded into the start edge so the final partial product lands
  // one cycle before the top level needs it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_acc    <= i_b[0] ? PW'(i_a) : '0;
        r_mcand  <= PW'(i_a) << 1;
        r_mplier <= i_b >> 1;
        r_cnt    <= CW'(1);
        r_run    <= 1'b1;
      end else if (r_run) begin
        r_acc    <= r_acc + w_pp;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CW'(1);
        if (r_cnt == CW'(WIDTH - 1)) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done    = r_done;
  assign o_product = r_acc;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith/shift ops plus an iterative multiply,
// with a registered valid/ready output stage.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             zero,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned SHW = shamt_width(WIDTH);
  localparam int unsigned AW  = WIDTH + 1;

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic               r_busy;
  logic               w_busy_nxt;
  logic               r_live;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  alu_flags_t         r_flags;

  logic               w_accept;
  logic               w_start_mul;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_product;
  logic               w_sub;
  logic [WIDTH-1:0]   w_b_eff;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;
  logic               w_cmsb;
  logic               w_ovf;
  logic [SHW-1:0]     w_shamt;
  logic [WIDTH-1:0]   w_res;
  alu_flags_t         w_flags;

  // r_live keeps in_ready low until the first edge after reset release.
  assign in_ready    = r_live && (r_state == ST_IDLE) && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_start_mul = w_accept && (op == OP_MUL);

  // One adder serves ADD, SUB and SLT.
  assign w_sub           = (op == OP_SUB) || (op == OP_SLT);
  assign w_b_eff         = w_sub ? ~operand_b : operand_b;
  assign {w_cout, w_sum} = AW'(operand_a) + AW'(w_b_eff) + AW'(w_sub);
  assign w_cmsb          = operand_a[WIDTH-1] ^ w_b_eff[WIDTH-1] ^ w_sum[WIDTH-1];
  assign w_ovf           = w_cmsb ^ w_cout;
  assign w_shamt         = operand_b[SHW-1:0];

  always_comb begin
    w_res   = '0;
    w_flags = '0;
    case (op)
      OP_ADD, OP_SUB: begin
        w_res         = w_sum;
        w_flags.carry = w_cout;
        w_flags.ovf   = w_ovf;
      end
      OP_SLT: begin
        w_res         = WIDTH'(w_sum[WIDTH-1] ^ w_ovf);
        w_flags.carry = w_cout;
        w_flags.ovf   = w_ovf;
      end
      OP_XOR:  w_res = operand_a ^ operand_b;
      OP_AND:  w_res = operand_a & operand_b;
      OP_NAND: w_res = ~(operand_a & operand_b);
      OP_NOR:  w_res = ~(operand_a | operand_b);
      OP_OR:   w_res = operand_a | operand_b;
      OP_SLL:  w_res = operand_a << w_shamt;
      OP_SRL:  w_res = operand_a >> w_shamt;
      OP_SRA:  w_res = WIDTH'($signed(operand_a) >>> w_shamt);
      default: w_res = '0;
    endcase
    w_flags.zero = (w_res == '0);
  end

  alu_seq_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_start_mul),
    .i_a      (operand_a),
    .i_b      (operand_b),
    .o_done   (w_mul_done),
    .o_product(w_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_live  <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: if (w_start_mul) w_state_nxt = ST_MUL;
      ST_MUL:  if (w_mul_done)  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt == ST_MUL);
  end

  // Output stage: a new load wins over a drain, so back-to-back handshakes keep out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
    end else if (w_accept && (op != OP_MUL)) begin
      r_out_valid <= 1'b1;
      r_result    <= w_res;
      r_flags     <= w_flags;
    end else if (w_mul_done) begin
      r_out_valid   <= 1'b1;
      r_result      <= w_product[WIDTH-1:0];
      r_flags.carry <= 1'b0;
      r_flags.zero  <= (w_product[WIDTH-1:0] == '0);
      r_flags.ovf   <= |w_product[2*WIDTH-1:WIDTH];
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign carryout  = r_flags.carry;
  assign zero      = r_flags.zero;
  assign overflow  = r_flags.ovf;
  assign busy      = r_busy;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: 8- and 32-bit instances, directed corner cases plus random traffic
// scored against an arithmetic reference model.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       v8, rdy8, ov8, ordy8, c8, z8, f8, busy8;
  logic [3:0] op8;
  logic [7:0] a8, b8, res8;
  logic        v32, rdy32, ov32, ordy32, c32, z32, f32, busy32;
  logic [3:0]  op32;
  logic [31:0] a32, b32, res32;

  alu_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8), .op(op8),
    .operand_a(a8), .operand_b(b8), .out_valid(ov8), .out_ready(ordy8),
    .result(res8), .carryout(c8), .zero(z8), .overflow(f8), .busy(busy8)
  );

  alu_seq #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(rdy32), .op(op32),
    .operand_a(a32), .operand_b(b32), .out_valid(ov32), .out_ready(ordy32),
    .result(res32), .carryout(c32), .zero(z32), .overflow(f32), .busy(busy32)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [63:0] res;
    logic        c;
    logic        z;
    logic        v;
  } exp_t;

  // Reference: plain integer arithmetic on masked values.
  function automatic exp_t ref_alu(input int unsigned w, input logic [3:0] o,
                                   input logic [63:0] ai, input logic [63:0] bi);
    exp_t e;
    logic [63:0] m, a, b;
    logic [64:0] s;
    logic [127:0] p;
    longint sa, sb;
    int unsigned sh, amt;
    m  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    a  = ai & m;
    b  = bi & m;
    sa = a[w-1] ? longint'(a | ~m) : longint'(a);
    sb = b[w-1] ? longint'(b | ~m) : longint'(b);
    sh = 0;
    while ((1 << sh) < w) sh++;
    amt = 32'(b & ((64'd1 << sh) - 64'd1));
    e = '0;
    case (o)
      OP_ADD: begin
        s = 65'(a) + 65'(b);
        e.res = s[63:0] & m;
        e.c = s[w];
        e.v = (a[w-1] == b[w-1]) && (e.res[w-1] != a[w-1]);
      end
      OP_SUB, OP_SLT: begin
        e.res = (a - b) & m;
        e.c = (a >= b);
        e.v = (a[w-1] != b[w-1]) && (e.res[w-1] != a[w-1]);
        if (o == OP_SLT) e.res = (sa < sb) ? 64'd1 : 64'd0;
      end
      OP_XOR:  e.res = a ^ b;
      OP_AND:  e.res = a & b;
      OP_NAND: e.res = ~(a & b) & m;
      OP_NOR:  e.res = ~(a | b) & m;
      OP_OR:   e.res = a | b;
      OP_SLL:  e.res = (a << amt) & m;
      OP_SRL:  e.res = a >> amt;
      OP_SRA:  e.res = 64'(sa >>> amt) & m;
      OP_MUL: begin
        p = 128'(a) * 128'(b);
        e.res = p[63:0] & m;
        e.v = ((p >> w) != 128'd0);
      end
      default: e.res = 64'd0;
    endcase
    e.z = (e.res == 64'd0);
    return e;
  endfunction

  // Scoreboards: a handshake seen at the negedge completes on the next posedge.
  exp_t q8[$];
  exp_t q32[$];
  exp_t e8, e32;

  always @(negedge clk) begin
    if (!rst_n) begin
      q8.delete();
      q32.delete();
    end else begin
      if (ov8 && ordy8) begin
        chk("sb8_pending", 64'(q8.size() != 0), 64'd1);
        if (q8.size() != 0) begin
          e8 = q8.pop_front();
          chk("sb8_res", 64'(res8), e8.res);
          chk("sb8_flg", 64'({c8, z8, f8}), 64'({e8.c, e8.z, e8.v}));
        end
      end
      if (v8 && rdy8) q8.push_back(ref_alu(8, op8, 64'(a8), 64'(b8)));
      if (ov32 && ordy32) begin
        chk("sb32_pending", 64'(q32.size() != 0), 64'd1);
        if (q32.size() != 0) begin
          e32 = q32.pop_front();
          chk("sb32_res", 64'(res32), e32.res);
          chk("sb32_flg", 64'({c32, z32, f32}), 64'({e32.c, e32.z, e32.v}));
        end
      end
      if (v32 && rdy32) q32.push_back(ref_alu(32, op32, 64'(a32), 64'(b32)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pick(input int unsigned w);
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 5))
      0: r = 64'd0;
      1: r = '1;
      2: r = 64'd1 << (w - 1);
      3: r = (64'd1 << (w - 1)) - 64'd1;
      default: ;
    endcase
    return r;
  endfunction

  // Issue one op with out_ready high, wait for its result and check it.
  task automatic run_op(input bit n8, input logic [3:0] o, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] x_res, input logic [2:0] x_flg,
                        input string tag, output int lat, output int bcnt);
    bit acc;
    int guard;
    if (n8) begin v8 = 1; op8 = o; a8 = 8'(a); b8 = 8'(b); ordy8 = 1; end
    else begin v32 = 1; op32 = o; a32 = 32'(a); b32 = 32'(b); ordy32 = 1; end
    acc = 0;
    guard = 0;
    while (!acc && guard < 100) begin
      acc = n8 ? rdy8 : rdy32;
      tick();
      guard++;
    end
    chk({tag, "_acc"}, 64'(acc), 64'd1);
    v8 = 0;
    v32 = 0;
    lat = 1;
    bcnt = 0;
    while (!(n8 ? ov8 : ov32) && lat < 100) begin
      if (n8 ? busy8 : busy32) bcnt++;
      tick();
      lat++;
    end
    chk({tag, "_res"}, n8 ? 64'(res8) : 64'(res32), x_res);
    chk({tag, "_flg"}, n8 ? 64'({c8, z8, f8}) : 64'({c32, z32, f32}), 64'(x_flg));
    if (n8) chk({tag, "_busy_end"}, 64'(busy8), 64'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time %0t exceeded, want finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bc, guard;
    bit acc;
    rst_n = 0;
    v8 = 1; op8 = OP_ADD; a8 = 8'h12; b8 = 8'h34; ordy8 = 1;
    v32 = 1; op32 = OP_ADD; a32 = 32'h1; b32 = 32'h2; ordy32 = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res8", 64'(res8), 64'd0);
    chk("rst_ctl8", 64'({rdy8, ov8, busy8, c8, z8, f8}), 64'd0);
    chk("rst_res32", 64'(res32), 64'd0);
    chk("rst_ctl32", 64'({rdy32, ov32, busy32, c32, z32, f32}), 64'd0);
    rst_n = 1;
    tick();
    chk("rdy8_after_rst", 64'(rdy8), 64'd1);
    chk("rdy32_after_rst", 64'(rdy32), 64'd1);
    v8 = 0;
    v32 = 0;
    tick();

    // Arithmetic flags, 32 bit
    run_op(0, OP_ADD, 64'h7FFF_FFFF, 64'h1, 64'h8000_0000, 3'b001, "add_ovf", lat, bc);
    chk("add_lat", 64'(lat), 64'd1);
    run_op(0, OP_SUB, 64'd5, 64'd5, 64'd0, 3'b110, "sub_zero", lat, bc);
    run_op(0, OP_SLT, 64'h8000_0000, 64'd1, 64'd1, 3'b101, "slt_neg", lat, bc);

    // Shifts, 8 bit
    run_op(1, OP_SRA, 64'h90, 64'hF9, 64'hC8, 3'b000, "sra", lat, bc);
    run_op(1, OP_SRL, 64'h90, 64'h01, 64'h48, 3'b000, "srl", lat, bc);
    run_op(1, OP_SLL, 64'h81, 64'h01, 64'h02, 3'b000, "sll", lat, bc);
    run_op(1, 4'd13, 64'h55, 64'hAA, 64'h00, 3'b010, "rsvd", lat, bc);

    // Multiply, 8 bit
    run_op(1, OP_MUL, 64'd15, 64'd17, 64'hFF, 3'b000, "mul_ff", lat, bc);
    chk("mul_lat", 64'(lat), 64'd9);
    chk("mul_busy_cycles", 64'(bc), 64'd8);
    run_op(1, OP_MUL, 64'd16, 64'd16, 64'h00, 3'b011, "mul_trunc", lat, bc);

    // Back-pressure: first result held while the consumer stalls
    ordy8 = 0; v8 = 1; op8 = OP_ADD; a8 = 8'd3; b8 = 8'd4;
    tick();
    op8 = OP_XOR; a8 = 8'h0F; b8 = 8'hF0;
    for (int k = 0; k < 4; k++) begin
      chk("bp_rdy_low", 64'(rdy8), 64'd0);
      chk("bp_hold", 64'({ov8, res8}), 64'h107);
      tick();
    end
    ordy8 = 1;
    #1;
    chk("bp_rdy_release", 64'(rdy8), 64'd1);
    tick();
    op8 = OP_AND; a8 = 8'hF0; b8 = 8'h3C;
    chk("bp_second", 64'({ov8, res8}), 64'h1FF);
    tick();
    v8 = 0;
    chk("bp_third", 64'({ov8, res8}), 64'h130);
    tick();
    chk("bp_drained", 64'(ov8), 64'd0);

    // Reset during a multiply
    v8 = 1; op8 = OP_MUL; a8 = 8'd7; b8 = 8'd9;
    acc = 0;
    guard = 0;
    while (!acc && guard < 100) begin
      acc = rdy8;
      tick();
      guard++;
    end
    chk("abort_acc", 64'(acc), 64'd1);
    v8 = 0;
    repeat (2) begin
      chk("abort_pre", 64'(ov8), 64'd0);
      tick();
    end
    rst_n = 0;
    #1;
    chk("abort_busy_clr", 64'(busy8), 64'd0);
    tick();
    tick();
    rst_n = 1;
    for (int i = 0; i < 12; i++) begin
      chk("abort_no_result", 64'(ov8), 64'd0);
      tick();
    end
    run_op(1, OP_ADD, 64'd2, 64'd3, 64'd5, 3'b000, "add_after_abort", lat, bc);

    // Random traffic on both widths against the model
    for (int cyc = 0; cyc < 500; cyc++) begin
      v8 = ($urandom_range(0, 3) != 0);
      op8 = 4'($urandom_range(0, 15));
      a8 = 8'(pick(8));
      b8 = 8'(pick(8));
      ordy8 = ($urandom_range(0, 3) != 0);
      v32 = ($urandom_range(0, 3) != 0);
      op32 = 4'($urandom_range(0, 15));
      a32 = 32'(pick(32));
      b32 = 32'(pick(32));
      ordy32 = ($urandom_range(0, 3) != 0);
      tick();
    end
    v8 = 0; v32 = 0; ordy8 = 1; ordy32 = 1;
    repeat (80) tick();
    chk("sb8_drained", 64'(q8.size()), 64'd0);
    chk("sb32_drained", 64'(q32.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
